// File: rtl/graphics_pkg.sv
// graphics_pkg
// Shared definitions for the graphics datapath blocks.
//   swapState_t  : swap-chain controller state encoding (IDLE / WAIT_FRAME / CLEAR)
//   BANK_0/BANK_1: framebuffer bank index constants
package graphics_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CLEAR      = 2'd2
   } swapState_t;

   localparam logic BANK_0 = 1'b0;
   localparam logic BANK_1 = 1'b1;

endpackage

// File: rtl/framebuffer_bank.sv
// framebuffer_bank
// WIDTH x DEPTH single-clock simple dual-port RAM: one write port and one
// registered read port. No reset on the storage or the read register; the
// owner decides when readData is meaningful.
// Ports:
//   clk                        clock
//   writeEnable/Address/Data   write port (address must be < DEPTH)
//   readEnable/readAddress     read request (address must be < DEPTH)
//   readData                   read result, updated only on a read, held otherwise
module framebuffer_bank #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2048,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             writeEnable,
   input  logic [AW-1:0]    writeAddress,
   input  logic [WIDTH-1:0] writeData,
   input  logic             readEnable,
   input  logic [AW-1:0]    readAddress,
   output logic [WIDTH-1:0] readData
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (writeEnable) begin
         mem[writeAddress] <= writeData;
      end
      if (readEnable) begin
         readData <= mem[readAddress];
      end
   end

endmodule

// File: rtl/framebuffer_swapchain.sv
// framebuffer_swapchain
// Double-buffered framebuffer. The draw side writes the back bank, scan-out
// reads the front bank. A swapRequest is held until the next frameStart so
// the bank flip always lands in vertical blank.
// Optional feature macro: FRAMEBUFFER_CLEAR_EN -- after each flip the new back
// bank is filled with clearColor (one word per cycle) before swapDone.
// Ports:
//   clk, resetN                     clock, asynchronous active-low reset
//   writeValid/writeReady           draw-side handshake: a write is accepted on
//                                   writeValid && writeReady; writeReady is high
//                                   only in IDLE. Out-of-range addresses are
//                                   accepted and dropped.
//   writeAddress, writeData         back-bank write
//   readEnable, readAddress         front-bank read request, available every cycle
//   readData, readValid             result one cycle later; readData holds between reads
//   frameStart                      vertical-blank pulse from video timing
//   swapRequest                     back buffer finished (ignored unless IDLE)
//   clearColor                      fill value, captured when a clear begins
//   swapDone                        one-cycle pulse when swap (and clear) finished
//   frontBank                       bank currently scanned out
//   busy                            controller not IDLE
//   debugState                      controller state, for observation
module framebuffer_swapchain
   import graphics_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2048,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             writeValid,
   output logic             writeReady,
   input  logic [AW-1:0]    writeAddress,
   input  logic [WIDTH-1:0] writeData,
   input  logic             readEnable,
   input  logic [AW-1:0]    readAddress,
   output logic [WIDTH-1:0] readData,
   output logic             readValid,
   input  logic             frameStart,
   input  logic             swapRequest,
   input  logic [WIDTH-1:0] clearColor,
   output logic             swapDone,
   output logic             frontBank,
   output logic             busy,
   output logic [1:0]       debugState
);

   localparam logic [AW:0] DEPTH_EXT = DEPTH[AW:0];

   swapState_t       state;
   logic             writeReadyQ;
   logic             busyQ;
   logic             swapDoneQ;
   logic             frontBankQ;

   logic             writeInRange;
   logic             readInRange;
   logic             writeFire;
   logic             backWriteEnable;
   logic [AW-1:0]    backWriteAddress;
   logic [WIDTH-1:0] backWriteData;

   logic [WIDTH-1:0] bank0Data;
   logic [WIDTH-1:0] bank1Data;
   logic             readValidQ;
   logic             readSelQ;
   logic             readZeroQ;

   assign writeInRange = ({1'b0, writeAddress} < DEPTH_EXT);
   assign readInRange  = ({1'b0, readAddress} < DEPTH_EXT);
   assign writeFire    = writeValid && writeReadyQ;

`ifdef FRAMEBUFFER_CLEAR_EN
   localparam int            LAST_INT  = DEPTH - 1;
   localparam logic [AW-1:0] LAST_ADDR = LAST_INT[AW-1:0];

   logic [AW-1:0]    clearCount;
   logic [WIDTH-1:0] clearColorQ;

   // Draw writes cannot occur during CLEAR (writeReady is low), so the clear
   // engine owns the back-bank write port for the whole fill.
   assign backWriteEnable  = (state == CLEAR) || (writeFire && writeInRange);
   assign backWriteAddress = (state == CLEAR) ? clearCount  : writeAddress;
   assign backWriteData    = (state == CLEAR) ? clearColorQ : writeData;
`else
   logic unusedClearColor;
   assign unusedClearColor = ^clearColor;

   assign backWriteEnable  = writeFire && writeInRange;
   assign backWriteAddress = writeAddress;
   assign backWriteData    = writeData;
`endif

   // Swap controller.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= IDLE;
         frontBankQ  <= BANK_0;
         writeReadyQ <= 1'b1;
         busyQ       <= 1'b0;
         swapDoneQ   <= 1'b0;
`ifdef FRAMEBUFFER_CLEAR_EN
         clearCount  <= '0;
         clearColorQ <= '0;
`endif
      end else begin
         swapDoneQ <= 1'b0;
         case (state)
            IDLE: begin
               // A frameStart in the same cycle is too early; the flip waits
               // for the next one.
               if (swapRequest) begin
                  state       <= WAIT_FRAME;
                  writeReadyQ <= 1'b0;
                  busyQ       <= 1'b1;
               end
            end
            WAIT_FRAME: begin
               if (frameStart) begin
                  frontBankQ <= ~frontBankQ;
`ifdef FRAMEBUFFER_CLEAR_EN
                  state       <= CLEAR;
                  clearCount  <= '0;
                  clearColorQ <= clearColor;
`else
                  state       <= IDLE;
                  writeReadyQ <= 1'b1;
                  busyQ       <= 1'b0;
                  swapDoneQ   <= 1'b1;
`endif
               end
            end
`ifdef FRAMEBUFFER_CLEAR_EN
            CLEAR: begin
               if (clearCount == LAST_ADDR) begin
                  state       <= IDLE;
                  writeReadyQ <= 1'b1;
                  busyQ       <= 1'b0;
                  swapDoneQ   <= 1'b1;
                  clearCount  <= '0;
               end else begin
                  clearCount <= clearCount + AW'(1);
               end
            end
`endif
            default: begin
               state       <= IDLE;
               writeReadyQ <= 1'b1;
               busyQ       <= 1'b0;
            end
         endcase
      end
   end

   // Back bank is always the one not being scanned out.
   framebuffer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bank0 (
      .clk          (clk),
      .writeEnable  (backWriteEnable && (frontBankQ == BANK_1)),
      .writeAddress (backWriteAddress),
      .writeData    (backWriteData),
      .readEnable   (readEnable && readInRange && (frontBankQ == BANK_0)),
      .readAddress  (readAddress),
      .readData     (bank0Data)
   );

   framebuffer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bank1 (
      .clk          (clk),
      .writeEnable  (backWriteEnable && (frontBankQ == BANK_0)),
      .writeAddress (backWriteAddress),
      .writeData    (backWriteData),
      .readEnable   (readEnable && readInRange && (frontBankQ == BANK_1)),
      .readAddress  (readAddress),
      .readData     (bank1Data)
   );

   // Read-side bookkeeping. The bank select and zero flag only move on a read,
   // so readData holds its last value between reads. readZeroQ resets high so
   // readData is 0 out of reset without resetting the RAM read registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         readValidQ <= 1'b0;
         readSelQ   <= BANK_0;
         readZeroQ  <= 1'b1;
      end else begin
         readValidQ <= readEnable;
         if (readEnable) begin
            readSelQ  <= frontBankQ;
            readZeroQ <= !readInRange;
         end
      end
   end

   assign readData   = readZeroQ ? '0 : ((readSelQ == BANK_1) ? bank1Data : bank0Data);
   assign readValid  = readValidQ;
   assign writeReady = writeReadyQ;
   assign busy       = busyQ;
   assign swapDone   = swapDoneQ;
   assign frontBank  = frontBankQ;
   assign debugState = state;

endmodule

// File: tb/tb_framebuffer_swapchain.sv
module tb_framebuffer_swapchain;
  import graphics_pkg::*;

  localparam int WIDTH = 9;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
`ifdef FRAMEBUFFER_CLEAR_EN
  localparam int SWAP_LAT = DEPTH;
`else
  localparam int SWAP_LAT = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             resetN;
  logic             writeValid;
  logic             writeReady;
  logic [AW-1:0]    writeAddress;
  logic [WIDTH-1:0] writeData;
  logic             readEnable;
  logic [AW-1:0]    readAddress;
  logic [WIDTH-1:0] readData;
  logic             readValid;
  logic             frameStart;
  logic             swapRequest;
  logic [WIDTH-1:0] clearColor;
  logic             swapDone;
  logic             frontBank;
  logic             busy;
  logic [1:0]       debugState;

  always #5 clk = ~clk;

  framebuffer_swapchain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .writeValid   (writeValid),
    .writeReady   (writeReady),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .readEnable   (readEnable),
    .readAddress  (readAddress),
    .readData     (readData),
    .readValid    (readValid),
    .frameStart   (frameStart),
    .swapRequest  (swapRequest),
    .clearColor   (clearColor),
    .swapDone     (swapDone),
    .frontBank    (frontBank),
    .busy         (busy),
    .debugState   (debugState)
  );

  // ---------------- model and scoreboard ----------------
  int errors = 0;
  int checks = 0;
  // MSB set = content unknown, compare skipped
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   monExp;
  logic [WIDTH-1:0] modelMem   [2][16];
  bit               modelKnown [2][16];
  logic             modelFront = 1'b0;
  bit               modelBusy  = 1'b0;
  logic [WIDTH-1:0] clrLatched = '0;

  always @(negedge clk) begin
    if (resetN === 1'b1 && readValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: readValid=1 got data %0h, none outstanding", readData);
      end else begin
        monExp = exp_q.pop_front();
        if (!monExp[WIDTH]) begin
          checks++;
          if (readData !== monExp[WIDTH-1:0]) begin
            errors++;
            $display("FAIL read_data: got %0h expected %0h", readData, monExp[WIDTH-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    readEnable  = 1'b1;
    readAddress = a;
    if (int'(a) >= DEPTH) exp_q.push_back('0);
    else if (!modelKnown[modelFront][a]) exp_q.push_back({1'b1, {WIDTH{1'b0}}});
    else exp_q.push_back({1'b0, modelMem[modelFront][a]});
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (!modelBusy && int'(a) < DEPTH) begin
      modelMem[~modelFront][a]   = d;
      modelKnown[~modelFront][a] = 1'b1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    writeValid = 1'b1; writeAddress = a; writeData = d;
    model_write(a, d);
    tick();
    writeValid = 1'b0;
  endtask

  task automatic swap_request();
    swapRequest = 1'b1;
    tick();
    swapRequest = 1'b0;
    modelBusy = 1'b1;
    checks++;
    if (busy !== 1'b1 || writeReady !== 1'b0 || debugState !== WAIT_FRAME) begin
      errors++;
      $display("FAIL swap_request_state: busy=%0b writeReady=%0b state=%0d want 1 0 %0d",
               busy, writeReady, debugState, WAIT_FRAME);
    end
  endtask

  // frameStart cycle, optional read in that cycle and the next, then wait for swapDone.
  task automatic pulse_frame(input bit withRead, input logic [AW-1:0] a);
    int n;
    int lowErr;
    frameStart = 1'b1;
    if (withRead) drive_read(a);
    clrLatched = clearColor;
    tick();
    frameStart = 1'b0;
    modelFront = ~modelFront;
    if (withRead) drive_read(a);
`ifdef FRAMEBUFFER_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      modelMem[~modelFront][i]   = clrLatched;
      modelKnown[~modelFront][i] = 1'b1;
    end
`endif
    n = 0;
    lowErr = 0;
    while (swapDone !== 1'b1 && n < 200) begin
      if (writeReady !== 1'b0 || busy !== 1'b1) lowErr++;
      tick();
      readEnable = 1'b0;
      n++;
      if (n == 1) clearColor = ~clrLatched;
    end
    clearColor = clrLatched;
    checks++;
    if (n !== SWAP_LAT || lowErr != 0) begin
      errors++;
      $display("FAIL swap_latency: swapDone after %0d cycles (busy/ready errs %0d) want %0d",
               n, lowErr, SWAP_LAT);
    end
    checks++;
    if (frontBank !== modelFront || busy !== 1'b0 || writeReady !== 1'b1) begin
      errors++;
      $display("FAIL swap_done_state: frontBank=%0b busy=%0b writeReady=%0b want %0b 0 1",
               frontBank, busy, writeReady, modelFront);
    end
    modelBusy = 1'b0;
    tick();
    readEnable = 1'b0;
    checks++;
    if (swapDone !== 1'b0) begin
      errors++;
      $display("FAIL swap_done_pulse: swapDone=%0b one cycle later want 0", swapDone);
    end
  endtask

  task automatic do_swap();
    swap_request();
    pulse_frame(1'b0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 1'b0;
    writeValid = 0; writeAddress = '0; writeData = '0;
    readEnable = 0; readAddress = '0; frameStart = 0; swapRequest = 0;
    clearColor = 9'h0FF;
    repeat (3) tick();
    checks++;
    if (writeReady !== 1'b1 || readData !== '0 || readValid !== 1'b0 ||
        swapDone !== 1'b0 || frontBank !== 1'b0 || busy !== 1'b0 || debugState !== IDLE) begin
      errors++;
      $display("FAIL reset_values: ready=%0b rdata=%0h rvalid=%0b done=%0b front=%0b busy=%0b st=%0d",
               writeReady, readData, readValid, swapDone, frontBank, busy, debugState);
    end
    resetN = 1'b1;
    tick();
    drive_read(4'd5);
    tick();
    readEnable = 1'b0;
    checks++;
    if (readValid !== 1'b1 || frontBank !== 1'b0 || writeReady !== 1'b1 || swapDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_read: rvalid=%0b front=%0b ready=%0b done=%0b want 1 0 1 0",
               readValid, frontBank, writeReady, swapDone);
    end
    tick();
    checks++;
    if (readValid !== 1'b0) begin
      errors++;
      $display("FAIL read_valid_drop: readValid=%0b want 0", readValid);
    end
  endtask

  task automatic test_swap_basic();
    do_write(4'd10, 9'h1AB);
    do_swap();
    checks++;
    if (frontBank !== 1'b1) begin
      errors++;
      $display("FAIL swap_toggle: frontBank=%0b want 1", frontBank);
    end
    drive_read(4'd10);
    tick();
    readEnable = 1'b0;
    do_write(4'd10, 9'h055);
    // read in the frameStart cycle sees the old front, the next read the new one
    swap_request();
    pulse_frame(1'b1, 4'd10);
    tick();
  endtask

  task automatic test_same_cycle();
    logic startFront;
    startFront = modelFront;
    swapRequest = 1'b1; frameStart = 1'b1;
    tick();
    swapRequest = 1'b0; frameStart = 1'b0;
    modelBusy = 1'b1;
    repeat (2) tick();
    checks++;
    if (frontBank !== startFront || busy !== 1'b1 || swapDone !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_hold: frontBank=%0b busy=%0b done=%0b want %0b 1 0",
               frontBank, busy, swapDone, startFront);
    end
    pulse_frame(1'b0, '0);
  endtask

  task automatic test_wait_frame_block();
    do_write(4'd3, 9'h0A5);
    swap_request();
    writeValid = 1'b1; writeAddress = 4'd3; writeData = 9'h15A;
    swapRequest = 1'b1;
    checks++;
    if (writeReady !== 1'b0) begin
      errors++;
      $display("FAIL wait_frame_ready: writeReady=%0b want 0", writeReady);
    end
    model_write(4'd3, 9'h15A);
    tick();
    writeValid = 1'b0; swapRequest = 1'b0;
    pulse_frame(1'b0, '0);
    drive_read(4'd3);
    frameStart = 1'b1;
    tick();
    readEnable = 1'b0; frameStart = 1'b0;
    tick();
    checks++;
    if (frontBank !== modelFront || busy !== 1'b0 || swapDone !== 1'b0) begin
      errors++;
      $display("FAIL single_toggle: frontBank=%0b busy=%0b done=%0b want %0b 0 0",
               frontBank, busy, swapDone, modelFront);
    end
  endtask

  task automatic test_boundary();
    do_write(4'd11, 9'h133);
    do_write(4'd12, 9'h1EE);
    do_write(4'd0, 9'h07C);
    checks++;
    if (writeReady !== 1'b1) begin
      errors++;
      $display("FAIL oor_handshake: writeReady=%0b want 1", writeReady);
    end
    do_swap();
    drive_read(4'd11); tick();
    drive_read(4'd12); tick();
    drive_read(4'd15); tick();
    drive_read(4'd0);  tick();
    readEnable = 1'b0;
    repeat (2) tick();
    checks++;
    if (readValid !== 1'b0 || readData !== 9'h07C) begin
      errors++;
      $display("FAIL read_hold: readValid=%0b readData=%0h want 0 7c", readValid, readData);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = WIDTH'($urandom_range(0, 511));
      writeValid = 1'b1; writeAddress = AW'(i); writeData = d;
      model_write(AW'(i), d);
      tick();
    end
    writeValid = 1'b0;
    do_swap();
    // reads on the front while random writes land in the back
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, 15));
      drive_read(a);
      d = WIDTH'($urandom_range(0, 511));
      writeValid = 1'b1; writeAddress = AW'($urandom_range(0, 15)); writeData = d;
      model_write(writeAddress, d);
      tick();
    end
    readEnable = 1'b0; writeValid = 1'b0;
    tick();
  endtask

  task automatic test_clear_fill();
    clearColor = 9'h0FF;
    do_swap();
    do_swap();
    for (int i = 0; i < DEPTH; i++) begin
      drive_read(AW'(i));
      tick();
    end
    readEnable = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int doneSeen;
    swap_request();
`ifdef FRAMEBUFFER_CLEAR_EN
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    repeat (3) tick();
`endif
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (frontBank !== 1'b0 || busy !== 1'b0 || writeReady !== 1'b1 ||
        swapDone !== 1'b0 || readData !== '0 || debugState !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: front=%0b busy=%0b ready=%0b done=%0b rdata=%0h st=%0d",
               frontBank, busy, writeReady, swapDone, readData, debugState);
    end
    @(posedge clk);
    #1 resetN = 1'b1;
    modelFront = 1'b0;
    modelBusy  = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) modelKnown[b][i] = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (i == 1) frameStart = 1'b1;
      tick();
      frameStart = 1'b0;
      if (swapDone !== 1'b0) doneSeen++;
    end
    checks++;
    if (doneSeen != 0 || frontBank !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: swapDone seen %0d times front=%0b busy=%0b want 0 0 0",
               doneSeen, frontBank, busy);
    end
    do_write(4'd7, 9'h0C3);
    do_swap();
    drive_read(4'd7);
    tick();
    readEnable = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_swap_basic();
    test_same_cycle();
    test_wait_frame_block();
    test_boundary();
    test_back_to_back();
    test_clear_fill();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_outstanding: %0d reads never returned, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
